// File: rtl/pll_reset_seq.sv
// PLL reset sequencer and lock supervisor, clocked from the free-running board reference clock.
// Optional `PLL_LOCK_LOSS_COUNT_EN` adds a saturating lock_loss_cnt output counting RUN lock losses.
module pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       running,
    output logic       fail,
    output logic [1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        if (v == 2'd3) begin
            return 2'd3;
        end else begin
            return v + 2'd1;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_cnt_q, retry_cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             running_q, running_d;
    logic             fail_q, fail_d;
    logic             lock_s;
    logic [2:0]       retry_next_s;
    logic             retry_limit_s;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0]       lock_loss_cnt_q, lock_loss_cnt_d;
`endif

    assign lock_s        = sync2_q;
    assign retry_next_s  = {1'b0, retry_cnt_q} + 3'd1;
    assign retry_limit_s = (32'(retry_next_s) >= 32'(MAX_RETRIES));

    // Two-flop synchronizer inputs for the asynchronous PLL lock.
    always_comb begin
        sync1_d = pll_locked;
        sync2_d = sync1_q;
    end

    // Next-state, counter and retry bookkeeping; software request overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_cnt_d = retry_cnt_q;
`ifdef PLL_LOCK_LOSS_COUNT_EN
        lock_loss_cnt_d = lock_loss_cnt_q;
`endif
        if (sw_reset_req) begin
            state_d     = ST_RESET_PLL;
            cnt_d       = CNT_ZERO;
            retry_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_cnt_d = sat_inc2(retry_cnt_q);
                        cnt_d       = CNT_ZERO;
                        if (retry_limit_s) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET_PLL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        // A lock glitch restarts the stability window without costing a retry.
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d     = ST_RUN;
                        cnt_d       = CNT_ZERO;
                        retry_cnt_d = 2'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = CNT_ZERO;
`ifdef PLL_LOCK_LOSS_COUNT_EN
                        lock_loss_cnt_d = sat_inc8(lock_loss_cnt_q);
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_n_d = (state_d == ST_RUN);
        running_d   = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    // State, counter, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= CNT_ZERO;
            retry_cnt_q <= 2'd0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            running_q   <= running_d;
            fail_q      <= fail_d;
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    // Lock-loss statistic survives software restarts; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt_q <= 8'd0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign running   = running_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus randomized lock/request
// traffic, compared against a phase/countdown reference model.
module tb_pll_reset_seq;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES    = 3;
    localparam int CNT_W          = 6;

    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STAB   = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       running;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    pll_reset_seq #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .running      (running),
        .fail         (fail),
        .retry_cnt    (retry_cnt)
`ifdef PLL_LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus cycles-remaining countdown and a 2-deep lock delay line.
    int m_phase;
    int m_left;
    int m_retries;
    int m_losses;
    bit m_s1;
    bit m_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 30) begin
                $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
            end
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_PLLRST;
        m_left    = PLL_RST_CYCLES;
        m_retries = 0;
        m_losses  = 0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    task automatic model_edge(input bit lk, input bit rq);
        bit ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (rq) begin
            m_phase   = PH_PLLRST;
            m_left    = PLL_RST_CYCLES;
            m_retries = 0;
        end else begin
            case (m_phase)
                PH_PLLRST: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_WAIT;
                        m_left  = LOCK_TIMEOUT;
                    end
                end
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_STAB;
                        m_left  = STABLE_CYCLES;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase   = (m_retries + 1 >= MAX_RETRIES) ? PH_FAIL : PH_PLLRST;
                            m_retries = (m_retries >= 3) ? 3 : m_retries + 1;
                            m_left    = PLL_RST_CYCLES;
                        end
                    end
                end
                PH_STAB: begin
                    if (!ls) begin
                        m_phase = PH_WAIT;
                        m_left  = LOCK_TIMEOUT;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase   = PH_RUN;
                            m_retries = 0;
                        end
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        m_phase  = PH_PLLRST;
                        m_left   = PLL_RST_CYCLES;
                        m_losses = (m_losses >= 255) ? 255 : m_losses + 1;
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        check("pll_rst",   32'(pll_rst),   32'((m_phase == PH_PLLRST) || (m_phase == PH_FAIL)));
        check("sys_rst_n", 32'(sys_rst_n), 32'(m_phase == PH_RUN));
        check("running",   32'(running),   32'(m_phase == PH_RUN));
        check("fail",      32'(fail),      32'(m_phase == PH_FAIL));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retries));
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_losses));
`endif
    endtask

    task automatic step();
        bit lk;
        bit rq;
        lk = pll_locked;
        rq = sw_reset_req;
        @(posedge clk);
        model_edge(lk, rq);
        #1;
        check_outputs();
    endtask

    // Assert rst_n between edges, check reset values without a clock edge, then release.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pll_rst",   32'(pll_rst),   32'd1);
        check("arst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("arst_running",   32'(running),   32'd0);
        check("arst_fail",      32'(fail),      32'd0);
        check("arst_retry_cnt", 32'(retry_cnt), 32'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("arst_lock_loss", 32'(lock_loss_cnt), 32'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int hi;
        int run_len;
        int pulses;
        int hold;
        bit prev;
        bit sys_seen;
        logic [1:0] retry_before;

        // Scenario 1: reset state, 4-cycle PLL reset pulse, lock then release at edge 10.
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pll_rst) hi++;
        end
        check("s1_pll_rst_len", 32'(hi), 32'd4);
        pll_locked = 1'b1;
        k = 0;
        while (!sys_rst_n && k < 40) begin
            step();
            k++;
        end
        check("s1_sysrst_edges", 32'(k), 32'd11);
        check("s1_running", 32'(running), 32'd1);
        check("s1_retry", 32'(retry_cnt), 32'd0);

        // Scenario 4: lock loss in RUN; sampling edge plus two sync edges.
        pll_locked = 1'b0;
        k = 0;
        while (sys_rst_n && k < 10) begin
            step();
            k++;
        end
        check("s4_drop_edges", 32'(k), 32'd3);
        check("s4_pll_rst", 32'(pll_rst), 32'd1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("s4_lock_loss", 32'(lock_loss_cnt), 32'd1);
`endif

        // Scenario 3: one-cycle lock drop at stable count 5 forces a fresh stability window.
        pll_locked = 1'b1;
        k = 0;
        while (!(m_phase == PH_STAB && m_left == STABLE_CYCLES - 5) && k < 60) begin
            step();
            k++;
        end
        check("s3_reach_stable", 32'(k < 60), 32'd1);
        retry_before = retry_cnt;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        k = 1;
        while (!sys_rst_n && k < 60) begin
            step();
            k++;
        end
        check("s3_rerun_edges", 32'(k), 32'd12);
        check("s3_retry_kept", 32'(retry_cnt), 32'(retry_before));

        // Scenario 6: asynchronous reset in the middle of STABLE.
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) step();
        pll_locked = 1'b1;
        k = 0;
        while (m_phase != PH_STAB && k < 40) begin
            step();
            k++;
        end
        check("s6_reach_stable", 32'(k < 40), 32'd1);
        async_reset();

        // Scenario 2: no lock at all -> three pulses, retries 1..3, then FAIL.
        pll_locked = 1'b0;
        prev = 1'b1;
        run_len = 1;
        pulses = 1;
        sys_seen = 1'b0;
        k = 0;
        while (!fail && k < 200) begin
            step();
            k++;
            if (sys_rst_n) sys_seen = 1'b1;
            if (pll_rst == prev) begin
                run_len++;
            end else begin
                if (prev) check("s2_hi_len", 32'(run_len), 32'd4);
                else      check("s2_lo_len", 32'(run_len), 32'd32);
                if (pll_rst && !fail) begin
                    pulses++;
                    check("s2_retry_step", 32'(retry_cnt), 32'(pulses - 1));
                end
                run_len = 1;
                prev = pll_rst;
            end
        end
        check("s2_pulses", 32'(pulses), 32'd3);
        check("s2_fail", 32'(fail), 32'd1);
        check("s2_retry_final", 32'(retry_cnt), 32'd3);
        check("s2_sysrst_low", 32'(sys_seen), 32'd0);

        // Scenario 5: software request leaves FAIL and the sequence reaches RUN.
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("s5_fail_clr", 32'(fail), 32'd0);
        check("s5_retry_clr", 32'(retry_cnt), 32'd0);
        check("s5_pll_rst", 32'(pll_rst), 32'd1);
        pll_locked = 1'b1;
        hi = 1;
        k = 0;
        while (!running && k < 60) begin
            step();
            k++;
            if (pll_rst) hi++;
        end
        check("s5_pulse_len", 32'(hi), 32'd4);
        check("s5_running", 32'(running), 32'd1);

        // Randomized lock traffic, rare software requests and rare async resets.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pll_locked = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 80));
            end
            hold--;
            sw_reset_req = ($urandom_range(0, 149) == 0);
            step();
            if ($urandom_range(0, 399) == 0) begin
                sw_reset_req = 1'b0;
                async_reset();
            end
        end
        sw_reset_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
